// File: rtl/sha256d_nonce_sweeper.sv
// sha256d_nonce_sweeper: steps a nonce range through a sha256 core as double SHA-256
// and reports the first nonce whose byte-reversed digest is at or below the target.
module sha256d_nonce_sweeper (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic          abort,
  input  logic [639:0]  header,
  input  logic [31:0]   nonce_start,
  input  logic [31:0]   nonce_end,
  input  logic [255:0]  target,
  output logic          busy,
  output logic          found,
  output logic          exhausted,
  output logic [31:0]   found_nonce,
  output logic [31:0]   hash_count,
  output logic          sha_reset,
  output logic          sha_start,
  output logic [1:0]    sha_num_chunks,
  output logic [1023:0] sha_str,
  input  logic          sha_done,
  input  logic [255:0]  sha_hash
);
  typedef enum logic [2:0] {IDLE, RUN1, DROP1, RUN2, DROP2, CHECK} state_t;
  state_t state, state_nxt;
  logic [607:0] hdr;
  logic [31:0] cur_nonce, end_nonce;
  logic [255:0] tgt, hash1, hash2, val;
  logic win, pass1, pass2;
  logic unused_nonce_field;
  assign unused_nonce_field = ^header[31:0];
  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign val[8*i +: 8] = hash2[8*(31-i) +: 8];
  end
  assign win = val <= tgt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else
      case (state)
        IDLE:    state_nxt = go ? RUN1 : IDLE;
        RUN1:    state_nxt = sha_done ? DROP1 : RUN1;
        DROP1:   state_nxt = sha_done ? DROP1 : RUN2;
        RUN2:    state_nxt = sha_done ? DROP2 : RUN2;
        DROP2:   state_nxt = sha_done ? DROP2 : CHECK;
        CHECK:   state_nxt = (win || cur_nonce == end_nonce) ? IDLE : RUN1;
        default: state_nxt = IDLE;
      endcase
  end
  // message follows the pass, so it is stable across each start/drop pair
  assign busy = state != IDLE;
  assign sha_start = state == RUN1 || state == RUN2;
  assign pass1 = state == RUN1 || state == DROP1;
  assign pass2 = state == RUN2 || state == DROP2 || state == CHECK;
  assign sha_num_chunks = pass1 ? 2'd2 : pass2 ? 2'd1 : 2'd0;
  assign sha_str = pass1 ? {hdr, cur_nonce[7:0], cur_nonce[15:8], cur_nonce[23:16], cur_nonce[31:24],
                            8'h80, 312'd0, 64'd640}
                 : pass2 ? {hash1, 8'h80, 184'd0, 64'd256, 512'd0} : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sha_reset <= 1'b1;
      hdr <= '0;
      cur_nonce <= '0;
      end_nonce <= '0;
      tgt <= '0;
      hash1 <= '0;
      hash2 <= '0;
      found <= 1'b0;
      exhausted <= 1'b0;
      found_nonce <= '0;
      hash_count <= '0;
    end else begin
      sha_reset <= abort;
      if (!abort) begin
        if (state == IDLE && go) begin
          hdr <= header[639:32];
          cur_nonce <= nonce_start;
          end_nonce <= nonce_end;
          tgt <= target;
          found <= 1'b0;
          exhausted <= 1'b0;
          hash_count <= '0;
        end
        if (state == RUN1 && sha_done) hash1 <= sha_hash;
        if (state == RUN2 && sha_done) hash2 <= sha_hash;
        if (state == DROP2 && !sha_done && hash_count != '1) hash_count <= hash_count + 32'd1;
        if (state == CHECK) begin
          if (win) begin
            found <= 1'b1;
            found_nonce <= cur_nonce;
          end else if (cur_nonce == end_nonce) exhausted <= 1'b1;
          else cur_nonce <= cur_nonce + 32'd1;
        end
      end
    end
endmodule
